// File: rtl/rr_encoder16_1_if.sv
// Request/emission bundle for rr_encoder16_1: request lines in, index stream out.
// The slave modport is the encoder side; master is the event source plus consumer.
interface rr_encoder16_1_if #(
    parameter int N     = 16,
    parameter int SEL_W = 4
);
    logic [N-1:0]     in;
    logic [SEL_W-1:0] out_sel;
    logic             out_valid;
    logic             out_ready;
    logic [N-1:0]     pend;

    modport master (
        output in,
        output out_ready,
        input  out_sel,
        input  out_valid,
        input  pend
    );

    modport slave (
        input  in,
        input  out_ready,
        output out_sel,
        output out_valid,
        output pend
    );
endinterface

// File: rtl/rr_encoder16_1.sv
// Collects N request lines into pending bits and emits each once as an index on a
// valid/ready stream. Define RR_ENC_FIXED_PRIO_EN for lowest-index-first instead of round-robin.
module rr_encoder16_1 #(
    parameter int N     = 16,
    parameter int SEL_W = 4
) (
    input logic            clk,
    input logic            rst_n,
    rr_encoder16_1_if.slave bus
);

    typedef enum logic {
        IDLE,
        BUSY
    } state_t;

    state_t           state;
    state_t           next_state;
    logic [SEL_W-1:0] ptr;
    logic [SEL_W-1:0] next_ptr;
    logic [SEL_W-1:0] sel_reg;
    logic [SEL_W-1:0] next_sel;
    logic [SEL_W-1:0] scan_idx;
    logic [SEL_W-1:0] found_idx;
    logic             found;
    logic             handshake;
    logic [N-1:0]     pend_reg;
    logic [N-1:0]     next_pend;
    logic [N-1:0]     clear_mask;

    always_comb begin
        next_state = state;
        next_ptr   = ptr;
        next_sel   = sel_reg;
        clear_mask = '0;
        found      = 1'b0;
        found_idx  = '0;
        scan_idx   = '0;
        handshake  = (state == BUSY) && bus.out_ready;

        // Scan from ptr upward; the SEL_W-bit add wraps N-1 back to 0 since N == 2**SEL_W.
        for (int k = 0; k < N; k++) begin
            scan_idx = ptr + SEL_W'(k);
            if (!found && pend_reg[scan_idx]) begin
                found     = 1'b1;
                found_idx = scan_idx;
            end
        end

        case (state)
            IDLE: begin
                if (found) begin
                    next_sel   = found_idx;
                    next_state = BUSY;
                end
            end
            BUSY: begin
                if (handshake) begin
                    clear_mask[sel_reg] = 1'b1;
                    next_ptr            = sel_reg + SEL_W'(1);
                    next_state          = IDLE;
                end
            end
            default: next_state = IDLE;
        endcase

`ifdef RR_ENC_FIXED_PRIO_EN
        next_ptr = '0;
`else
`endif

        // New requests are OR-ed in after the clear so a same-edge re-request survives.
        next_pend = (pend_reg & ~clear_mask) | bus.in;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            ptr      <= '0;
            sel_reg  <= '0;
            pend_reg <= '0;
        end else begin
            state    <= next_state;
            ptr      <= next_ptr;
            sel_reg  <= next_sel;
            pend_reg <= next_pend;
        end
    end

    assign bus.out_sel   = sel_reg;
    assign bus.out_valid = (state == BUSY);
    assign bus.pend      = pend_reg;

endmodule
